// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch/PC stage.
package fetch_pkg;

    localparam int FETCH_PC_W    = 10;
    localparam int FETCH_INSTR_W = 9;
    localparam int FETCH_LUT_AW  = 4;

    localparam logic [FETCH_INSTR_W-1:0] FETCH_HALT_OP = 9'b111111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_branch_lut.sv
// Branch-target lookup table: combinational read, contents cleared by reset.
// Entries are normally preloaded from outside (loader or testbench) after reset.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int AW = FETCH_LUT_AW,
    parameter int DW = FETCH_PC_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] idx,
    output logic [DW-1:0] target
);

    localparam int N = 1 << AW;

    logic [DW-1:0] targets [N];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                targets[i] <= '0;
            end
        end
    end

    assign target = targets[idx];

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, run/halt control and LUT-based branch targeting for the core.
// Optional build macro FETCH_PERF_CNT_EN adds a saturating 16-bit instr_count.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                 PC_W    = FETCH_PC_W,
    parameter int                 INSTR_W = FETCH_INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_OP = FETCH_HALT_OP,
    parameter int                 LUT_AW  = FETCH_LUT_AW
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stall,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               branch_en,
    input  logic               branch_taken,
    input  logic [LUT_AW-1:0]  target_idx,
    output logic [PC_W-1:0]    PC,
    output logic               fetch_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        instr_count,
`endif
    output logic               halt,
    output fetch_state_t       state_dbg
);

    // Handshake: none; PC/Instruction is a live pair whenever fetch_valid=1,
    // and the stage only advances on cycles with stall=0.

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            halt_q, halt_d;
    logic            launch;
    logic            count_en;
    logic [PC_W-1:0] lut_target;

    branch_lut #(.AW(LUT_AW), .DW(PC_W)) lut1 (
        .clk     (CLK),
        .reset_n (reset_n),
        .idx     (target_idx),
        .target  (lut_target)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            halt_q        <= halt_d;
        end
    end

    // Stall outranks halt detection and branching; start only matters outside RUN.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        launch   = 1'b0;
        count_en = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    count_en = 1'b1;
                    if (Instruction == HALT_OP) begin
                        state_d = HALTED;
                    end else if (branch_en && branch_taken) begin
                        pc_d = lut_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_comb begin
        fetch_valid_d = (state_d == RUN);
        halt_d        = (state_d == HALTED);
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count_q;

    always_ff @(posedge CLK) begin
        if (!reset_n || launch) begin
            count_q <= '0;
        end else if (count_en && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`endif

    assign PC          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign halt        = halt_q;
    assign state_dbg   = state_q;

endmodule
